// File: rtl/ahfp_add_mc.sv
// ahfp_add_mc: multi-cycle IEEE-754 single-precision adder, round-to-nearest-even, denormals flushed.
// Define AHFP_ADD_SPECIALS_EN to decode inf/NaN operands instead of treating exponent 255 as ordinary.
module ahfp_add_mc (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic        done,
    output logic        busy,
    output logic [31:0] result
);
    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;
    state_t state;
    logic [31:0] op_a, op_b, pack, rpack, sp_val;
    logic sa, sb, sr, swap, rnd, sp_hit;
    logic signed [9:0] ea, er, ef;
    logic [26:0] ma, mb, ua, ub;
    logic [27:0] sm;
    logic [24:0] mr;
    logic [22:0] frac;
    logic [7:0] xa, xb, diff;
    logic [4:0] cnt, ediff;
    // mantissas carry {hidden, 23 fraction, guard, round, sticky}
    always_comb begin
        xa = op_a[30:23];
        xb = op_b[30:23];
        ua = (xa == 8'd0) ? 27'd0 : {1'b1, op_a[22:0], 3'b000};
        ub = (xb == 8'd0) ? 27'd0 : {1'b1, op_b[22:0], 3'b000};
        swap = {xb, ub} > {xa, ua};
        diff = swap ? xb - xa : xa - xb;
        ediff = (diff > 8'd26) ? 5'd26 : diff[4:0];
        rnd = sm[2] & (sm[1] | sm[0] | sm[3]);
        mr = {1'b0, sm[26:3]} + {24'd0, rnd};
        ef = mr[24] ? er + 10'sd1 : er;
        frac = mr[24] ? mr[23:1] : mr[22:0];
        rpack = (sm[26:0] == 27'd0) ? {sr, 31'h0} :
                (ef >= 10'sd255)    ? {sr, 31'h7F800000} :
                (ef <= 10'sd0)      ? {sr, 31'h0} : {sr, ef[7:0], frac};
`ifdef AHFP_ADD_SPECIALS_EN
        sp_hit = (&xa) | (&xb);
        sp_val = ((&xa && |op_a[22:0]) || (&xb && |op_b[22:0]) ||
                  (&xa && &xb && (op_a[31] ^ op_b[31]))) ? 32'h7FC00000 :
                 (&xa) ? op_a : op_b;
`else
        sp_hit = 1'b0;
        sp_val = 32'h0;
`endif
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            done <= 1'b0;
            busy <= 1'b0;
            result <= 32'h0;
        end else if (clk_en) begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    op_a <= dataa;
                    op_b <= datab;
                    busy <= 1'b1;
                    state <= UNPACK;
                end
                UNPACK: if (sp_hit) begin
                    pack <= sp_val;
                    state <= DONE;
                end else begin
                    sa <= swap ? op_b[31] : op_a[31];
                    sb <= swap ? op_a[31] : op_b[31];
                    ea <= {2'b00, swap ? xb : xa};
                    ma <= swap ? ub : ua;
                    mb <= swap ? ua : ub;
                    cnt <= ediff;
                    state <= ALIGN;
                end
                ALIGN: if (cnt != 5'd0) begin
                    mb <= {1'b0, mb[26:2], mb[1] | mb[0]};
                    cnt <= cnt - 5'd1;
                    state <= (cnt == 5'd1) ? ADD : ALIGN;
                end else begin
                    state <= ADD;
                end
                ADD: begin
                    sm <= (sa == sb) ? {1'b0, ma} + {1'b0, mb} : {1'b0, ma} - {1'b0, mb};
                    sr <= (sa != sb && ma == mb) ? 1'b0 : sa;
                    er <= ea;
                    state <= NORM;
                end
                NORM: if (sm[27]) begin
                    sm <= {1'b0, sm[27:2], sm[1] | sm[0]};
                    er <= er + 10'sd1;
                    state <= ROUND;
                end else if (sm == 28'd0 || sm[26]) begin
                    state <= ROUND;
                end else begin
                    sm <= {sm[26:0], 1'b0};
                    er <= er - 10'sd1;
                end
                ROUND: begin
                    pack <= rpack;
                    state <= DONE;
                end
                DONE: begin
                    result <= pack;
                    done <= 1'b1;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
